// File: rtl/pid_steer_pkg.sv
// Shared widths and default gains for the steering PID controller.
package pid_steer_pkg;

  // Input / saturation widths
  localparam int ERR_IN_W  = 12;  // raw error from the sensing front end
  localparam int ERR_W     = 10;  // saturated error
  localparam int FRWRD_W   = 10;  // unsigned forward speed command
  localparam int D_DIFF_W  = 11;  // error difference before saturation
  localparam int D_W       = 7;   // saturated error difference
  localparam int SPD_RAW_W = 13;  // wheel speed before saturation
  localparam int SPD_W     = 11;  // wheel speed command

  // Internal term widths
  localparam int P_TERM_W  = 14;
  localparam int D_TERM_W  = 13;
  localparam int INTEG_W   = 15;
  localparam int I_TERM_W  = 9;
  localparam int PID_W     = 15;
  localparam int CORR_W    = 12;

  // Gains
  localparam int P_COEFF_W = 5;
  localparam int D_COEFF_W = 6;
  localparam logic signed [P_COEFF_W-1:0] P_COEFF_DEF = 5'sh08;
  localparam logic signed [D_COEFF_W-1:0] D_COEFF_DEF = 6'sh0B;

endpackage

// File: rtl/pid_steer_sat.sv
// Generic signed saturator: clamps a wide two's complement value into OUT_W bits.
module pid_steer_sat #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout
);

  // In range when every bit from the output sign bit upward matches the input sign.
  always_comb begin
    if (i_din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){i_din[IN_W-1]}}) begin
      o_dout = i_din[OUT_W-1:0];
    end else if (i_din[IN_W-1]) begin
      o_dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      o_dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pid_steer.sv
// Steering PID: left/right wheel speeds = forward speed +/- PID correction.
// Outputs are combinational from the inputs and the integrator/previous-error state.
module pid_steer
  import pid_steer_pkg::*;
#(
  parameter logic signed [P_COEFF_W-1:0] P_COEFF = P_COEFF_DEF,
  parameter logic signed [D_COEFF_W-1:0] D_COEFF = D_COEFF_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       moving,
  input  logic                       err_vld,
  input  logic signed [ERR_IN_W-1:0] error,
  input  logic        [FRWRD_W-1:0]  frwrd,
  output logic signed [SPD_W-1:0]    lft_spd,
  output logic signed [SPD_W-1:0]    rght_spd
);

  logic signed [ERR_W-1:0]     w_err_sat;
  logic signed [P_TERM_W-1:0]  w_p_term;
  logic signed [INTEG_W-1:0]   r_integ;
  logic signed [INTEG_W-1:0]   w_err_ext;
  logic signed [INTEG_W-1:0]   w_integ_sum;
  logic                        w_integ_ovf;
  logic signed [I_TERM_W-1:0]  w_i_term;
  logic signed [ERR_W-1:0]     r_prev_err;
  logic signed [D_DIFF_W-1:0]  w_d_diff;
  logic signed [D_W-1:0]       w_d_sat;
  logic signed [D_TERM_W-1:0]  w_d_term;
  logic signed [PID_W-1:0]     w_pid;
  logic signed [CORR_W-1:0]    w_corr;
  logic signed [SPD_RAW_W-1:0] w_lft_raw;
  logic signed [SPD_RAW_W-1:0] w_rght_raw;
  logic signed [SPD_W-1:0]     w_lft_sat;
  logic signed [SPD_W-1:0]     w_rght_sat;

  pid_steer_sat #(.IN_W(ERR_IN_W), .OUT_W(ERR_W)) u_err_sat (
    .i_din  (error),
    .o_dout (w_err_sat)
  );

  // Proportional: operands sign-extended to the product width so the multiply is full signed.
  assign w_p_term = $signed({{(P_TERM_W-ERR_W){w_err_sat[ERR_W-1]}}, w_err_sat})
                  * $signed({{(P_TERM_W-P_COEFF_W){P_COEFF[P_COEFF_W-1]}}, P_COEFF});

  // Integrator with signed-overflow guard: an overflowing accumulate is dropped, not wrapped.
  assign w_err_ext   = $signed({{(INTEG_W-ERR_W){w_err_sat[ERR_W-1]}}, w_err_sat});
  assign w_integ_sum = r_integ + w_err_ext;
  assign w_integ_ovf = (r_integ[INTEG_W-1] == w_err_ext[INTEG_W-1]) &&
                       (w_integ_sum[INTEG_W-1] != r_integ[INTEG_W-1]);
  assign w_i_term    = r_integ[INTEG_W-1:INTEG_W-I_TERM_W];

  // Integrator state: cleared whenever the robot is stopped, otherwise accumulates on each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_integ <= '0;
    end else if (!moving) begin
      r_integ <= '0;
    end else if (err_vld && !w_integ_ovf) begin
      r_integ <= w_integ_sum;
    end
  end

  // Previous error sample, tracked regardless of moving so D has a valid history on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_err <= '0;
    end else if (err_vld) begin
      r_prev_err <= w_err_sat;
    end
  end

  // Derivative on the saturated error, clamped before the gain.
  assign w_d_diff = $signed({w_err_sat[ERR_W-1], w_err_sat})
                  - $signed({r_prev_err[ERR_W-1], r_prev_err});

  pid_steer_sat #(.IN_W(D_DIFF_W), .OUT_W(D_W)) u_d_sat (
    .i_din  (w_d_diff),
    .o_dout (w_d_sat)
  );

  assign w_d_term = $signed({{(D_TERM_W-D_W){w_d_sat[D_W-1]}}, w_d_sat})
                  * $signed({{(D_TERM_W-D_COEFF_W){D_COEFF[D_COEFF_W-1]}}, D_COEFF});

  // Adder tree; every term fits in PID_W so no intermediate saturation is needed.
  assign w_pid = $signed({{(PID_W-P_TERM_W){w_p_term[P_TERM_W-1]}}, w_p_term})
               + $signed({{(PID_W-I_TERM_W){w_i_term[I_TERM_W-1]}}, w_i_term})
               + $signed({{(PID_W-D_TERM_W){w_d_term[D_TERM_W-1]}}, w_d_term});

  assign w_corr = CORR_W'(w_pid >>> 3);

  // Wheel speeds at 13 bits (cannot overflow), then clamped to the drive range.
  assign w_lft_raw  = $signed({{(SPD_RAW_W-FRWRD_W){1'b0}}, frwrd})
                    + $signed({w_corr[CORR_W-1], w_corr});
  assign w_rght_raw = $signed({{(SPD_RAW_W-FRWRD_W){1'b0}}, frwrd})
                    - $signed({w_corr[CORR_W-1], w_corr});

  pid_steer_sat #(.IN_W(SPD_RAW_W), .OUT_W(SPD_W)) u_lft_sat (
    .i_din  (w_lft_raw),
    .o_dout (w_lft_sat)
  );

  pid_steer_sat #(.IN_W(SPD_RAW_W), .OUT_W(SPD_W)) u_rght_sat (
    .i_din  (w_rght_raw),
    .o_dout (w_rght_sat)
  );

  assign lft_spd  = moving ? w_lft_sat  : '0;
  assign rght_spd = moving ? w_rght_sat : '0;

endmodule

// File: tb/tb_pid_steer.sv
// Directed bench for pid_steer with hand-computed wheel speeds.
module tb_pid_steer;

  logic               clk;
  logic               rst_n;
  logic               moving;
  logic               err_vld;
  logic [11:0]        error;
  logic [9:0]         frwrd;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;

  int checks = 0;
  int errors = 0;

  pid_steer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [10:0] obs,
                     input logic signed [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input logic signed [10:0] exp_l,
                          input logic signed [10:0] exp_r);
    chk({tag, "_lft"}, lft_spd, exp_l);
    chk({tag, "_rght"}, rght_spd, exp_r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with robot stopped
    rst_n = 1'b0; moving = 1'b0; err_vld = 1'b0;
    frwrd = 10'h200; error = 12'h100;
    #1;
    chk_pair("in_reset", 11'sd0, 11'sd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_pair("stopped", 11'sd0, 11'sd0);

    // Straight line, zero error, zero state
    moving = 1'b1; error = 12'h000; frwrd = 10'h100;
    #1;
    chk_pair("straight", 11'sd256, -11'sd256 + 11'sd512);

    // Max positive error: P=4088, D=693, corr=597
    error = 12'h7FF; frwrd = 10'h000;
    #1;
    chk_pair("pos_err", 11'sd597, -11'sd597);

    // Max negative error: P=-4096, D=-704, corr=-600; right side clamps
    error = 12'h800; frwrd = 10'h3FF;
    #1;
    chk_pair("neg_err", 11'sd423, 11'sd1023);

    // Error toggles without err_vld: state must not move
    for (int i = 0; i < 4; i++) begin
      error = (i % 2 == 0) ? 12'h7FF : 12'h800;
      tick();
    end
    error = 12'h000; frwrd = 10'h100;
    #1;
    chk_pair("no_vld", 11'sd256, 11'sd256);

    // Single err_vld pulse with error 500: integ=500 (I=7), prev=500
    error = 12'd500; err_vld = 1'b1;
    tick();
    err_vld = 1'b0; frwrd = 10'h000;
    #1;
    chk_pair("one_pulse", 11'sd500, -11'sd500);
    tick();
    chk_pair("pulse_once", 11'sd500, -11'sd500);

    // Error returns to 0: D_diff=-500 clamps to -64, PID=-697, corr=-88
    error = 12'h000;
    #1;
    chk_pair("d_neg", -11'sd88, 11'sd88);

    // Stop for one cycle to clear the integrator
    moving = 1'b0;
    tick();
    chk_pair("stop_zero", 11'sd0, 11'sd0);

    // Windup: 200 samples of 511; integrator holds at 16352 (I=255)
    moving = 1'b1; error = 12'h1FF; err_vld = 1'b1;
    repeat (200) tick();
    err_vld = 1'b0; frwrd = 10'h000;
    #1;
    chk_pair("windup", 11'sd542, -11'sd542);

    // Full forward speed with integrator near max: left clamps, right no wrap
    frwrd = 10'h3FF;
    #1;
    chk_pair("spd_sat", 11'sd1023, 11'sd481);

    // Stopped with a sample present: clear wins over accumulate, prev still updates
    moving = 1'b0; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    chk_pair("stop_vld", 11'sd0, 11'sd0);
    moving = 1'b1; frwrd = 10'h000;
    #1;
    chk_pair("after_clear", 11'sd511, -11'sd511);

    // Asynchronous reset without a clock edge clears prev_err and integrator
    #2;
    rst_n = 1'b0;
    #1;
    error = 12'h000; frwrd = 10'h100;
    #1;
    chk_pair("async_rst", 11'sd256, 11'sd256);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
